// File: rtl/servant_spi_ram_slave_if.sv
// SPI link bundle between the servant SPI master and the serial-RAM responder.
interface servant_spi_ram_slave_if;
  logic spi_sck;
  logic spi_ss;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sck, output spi_ss, output spi_mosi, input spi_miso);
  modport slave  (input spi_sck, input spi_ss, input spi_mosi, output spi_miso);
endinterface

// File: rtl/servant_spi_ram_slave.sv
// 23LC-style SPI SRAM responder (READ/WRITE/RDSR/WREN/WRDI), oversampled in the clock domain.
// Define SPI_RAM_SLAVE_MISO_Z_EN to tristate spi_miso while deselected or in CMD/IGNORE.
module servant_spi_ram_slave #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int SPI_ADDR_BYTES = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  servant_spi_ram_slave_if.slave        spi,
  output logic                          wel,
  output logic                          byte_written,
  output logic                          cmd_error
);
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR, ST_DATA_RD, ST_DATA_WR, ST_STATUS, ST_IGNORE
  } state_t;

  state_t state_r, state_nxt_s;
  logic [1:0] sck_q_r, ss_q_r, mosi_q_r;
  logic       sck_d_r, armed_r;
  logic [2:0] bit_cnt_r;
  logic [1:0] addr_cnt_r;
  logic [6:0] shift_in_r;
  logic [23:0] addr_reg_r;
  logic       is_write_r, rd_pend_r, load_pend_r;
  logic [MEM_ADDR_WIDTH-1:0] index_r;
  logic [7:0] mem_q_r, tx_sh_r;
  logic       miso_r, wel_r, byte_written_r, cmd_error_r;
  logic [7:0] mem [0:DEPTH-1];

  logic sck_s, ss_s, mosi_s, rise_s, fall_s, byte_done_s, mem_we_s;
  logic cmd_error_s, wel_nxt_s, addr_last_s, unused_addr_s;
  logic [7:0] rx_byte_s, tx_src_s;
  logic [23:0] addr_full_s;

  assign sck_s       = sck_q_r[1];
  assign ss_s        = ss_q_r[1];
  assign mosi_s      = mosi_q_r[1];
  assign rise_s      = sck_s & ~sck_d_r & ~ss_s;
  assign fall_s      = ~sck_s & sck_d_r & ~ss_s;
  // armed_r blocks decoding after reset until the master has deselected once
  assign byte_done_s = rise_s & (bit_cnt_r == 3'd7) & armed_r;
  assign rx_byte_s   = {shift_in_r, mosi_s};
  assign addr_full_s = {addr_reg_r[15:0], rx_byte_s};
  assign addr_last_s = (addr_cnt_r == 2'(SPI_ADDR_BYTES - 1));
  assign mem_we_s    = byte_done_s & (state_r == ST_DATA_WR);
  assign unused_addr_s = ^{addr_reg_r[23:16], addr_full_s[23:MEM_ADDR_WIDTH]};

  assign wel          = wel_r;
  assign byte_written = byte_written_r;
  assign cmd_error    = cmd_error_r;

`ifdef SPI_RAM_SLAVE_MISO_Z_EN
  assign spi.spi_miso = (ss_s || state_r == ST_IGNORE || state_r == ST_CMD) ? 1'bz : miso_r;
`else
  assign spi.spi_miso = miso_r;
`endif

  // Next-state decode and command side effects
  always_comb begin
    state_nxt_s = state_r;
    cmd_error_s = 1'b0;
    wel_nxt_s   = wel_r;
    if (ss_s) begin
      state_nxt_s = ST_CMD;
    end else if (byte_done_s) begin
      case (state_r)
        ST_CMD: begin
          case (rx_byte_s)
            8'h03: state_nxt_s = ST_ADDR;
            8'h02: begin
              if (wel_r) begin
                state_nxt_s = ST_ADDR;
              end else begin
                state_nxt_s = ST_IGNORE;
                cmd_error_s = 1'b1;
              end
            end
            8'h05: state_nxt_s = ST_STATUS;
            8'h06: begin
              wel_nxt_s   = 1'b1;
              state_nxt_s = ST_IGNORE;
            end
            8'h04: begin
              wel_nxt_s   = 1'b0;
              state_nxt_s = ST_IGNORE;
            end
            default: begin
              state_nxt_s = ST_IGNORE;
              cmd_error_s = 1'b1;
            end
          endcase
        end
        ST_ADDR: begin
          if (addr_last_s) begin
            state_nxt_s = is_write_r ? ST_DATA_WR : ST_DATA_RD;
          end else begin
            state_nxt_s = ST_ADDR;
          end
        end
        default: state_nxt_s = state_r;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Byte to present on the next load: status register or fetched memory byte
  always_comb begin
    tx_src_s = mem_q_r;
    if (state_r == ST_STATUS) begin
      tx_src_s = {6'b0, wel_r, 1'b0};
    end else begin
      tx_src_s = mem_q_r;
    end
  end

  // State register and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_CMD;
      wel_r          <= 1'b0;
      cmd_error_r    <= 1'b0;
      byte_written_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      wel_r          <= wel_nxt_s;
      cmd_error_r    <= cmd_error_s;
      byte_written_r <= mem_we_s;
    end
  end

  // Synchronisers, bit/address counters, index and MISO shifter
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_q_r     <= 2'b11;
      sck_d_r     <= 1'b1;
      ss_q_r      <= 2'b00;
      mosi_q_r    <= 2'b00;
      armed_r     <= 1'b0;
      bit_cnt_r   <= 3'd0;
      addr_cnt_r  <= 2'd0;
      shift_in_r  <= 7'd0;
      addr_reg_r  <= 24'd0;
      is_write_r  <= 1'b0;
      rd_pend_r   <= 1'b0;
      load_pend_r <= 1'b0;
      index_r     <= '0;
      tx_sh_r     <= 8'd0;
      miso_r      <= 1'b0;
    end else begin
      sck_q_r  <= {sck_q_r[0], spi.spi_sck};
      sck_d_r  <= sck_q_r[1];
      ss_q_r   <= {ss_q_r[0], spi.spi_ss};
      mosi_q_r <= {mosi_q_r[0], spi.spi_mosi};
      if (ss_s) begin
        armed_r     <= 1'b1;
        bit_cnt_r   <= 3'd0;
        addr_cnt_r  <= 2'd0;
        rd_pend_r   <= 1'b0;
        load_pend_r <= 1'b0;
        miso_r      <= 1'b0;
      end else begin
        if (rise_s) begin
          bit_cnt_r  <= bit_cnt_r + 3'd1;
          shift_in_r <= rx_byte_s[6:0];
        end
        if (byte_done_s) begin
          case (state_r)
            ST_CMD: begin
              is_write_r  <= (rx_byte_s == 8'h02);
              load_pend_r <= (rx_byte_s == 8'h05);
            end
            ST_ADDR: begin
              addr_reg_r <= addr_full_s;
              addr_cnt_r <= addr_cnt_r + 2'd1;
              if (addr_last_s) begin
                index_r   <= addr_full_s[MEM_ADDR_WIDTH-1:0];
                rd_pend_r <= ~is_write_r;
              end
            end
            ST_DATA_RD: rd_pend_r   <= 1'b1;
            ST_DATA_WR: index_r     <= index_r + MEM_ADDR_WIDTH'(1);
            ST_STATUS:  load_pend_r <= 1'b1;
            default: ;
          endcase
        end
        // Read was issued this cycle; arm the shifter load and advance
        if (rd_pend_r) begin
          rd_pend_r   <= 1'b0;
          load_pend_r <= 1'b1;
          index_r     <= index_r + MEM_ADDR_WIDTH'(1);
        end
        if (fall_s) begin
          if (state_r == ST_DATA_RD || state_r == ST_STATUS) begin
            if (load_pend_r) begin
              miso_r      <= tx_src_s[7];
              tx_sh_r     <= {tx_src_s[6:0], 1'b0};
              load_pend_r <= 1'b0;
            end else begin
              miso_r  <= tx_sh_r[7];
              tx_sh_r <= {tx_sh_r[6:0], 1'b0};
            end
          end else begin
            miso_r <= 1'b0;
          end
        end
      end
    end
  end

  // Single-port byte memory, not reset
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem[index_r] <= rx_byte_s;
    end
    if (rd_pend_r) begin
      mem_q_r <= mem[index_r];
    end
  end
endmodule

// File: tb/tb_servant_spi_ram_slave.sv
// Directed bench for servant_spi_ram_slave: hand-written command sequences plus a read-back table.
module tb_servant_spi_ram_slave;
  localparam int HALF = 6;

  logic clock = 1'b0;
  logic reset;
  logic wel, byte_written, cmd_error;
  int n_checks = 0;
  int n_errors = 0;
  int bw_cnt = 0;
  int ce_cnt = 0;

  always #5 clock = ~clock;

  servant_spi_ram_slave_if bus ();

  servant_spi_ram_slave #(.MEM_ADDR_WIDTH(10), .SPI_ADDR_BYTES(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .spi          (bus.slave),
    .wel          (wel),
    .byte_written (byte_written),
    .cmd_error    (cmd_error)
  );

  always @(negedge clock) begin
    if (byte_written === 1'b1) bw_cnt++;
    if (cmd_error === 1'b1) ce_cnt++;
  end

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  exp;
  } rd_vec_t;

  rd_vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clock);
      bus.spi_sck  = 1'b0;
      bus.spi_mosi = tx[i];
      repeat (HALF) @(negedge clock);
      rx[i] = bus.spi_miso;
      bus.spi_sck = 1'b1;
      repeat (HALF - 1) @(negedge clock);
    end
  endtask

  task automatic sel();
    @(negedge clock);
    bus.spi_ss = 1'b0;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic desel();
    repeat (HALF) @(negedge clock);
    bus.spi_ss = 1'b1;
    repeat (2 * HALF) @(negedge clock);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] d;
    xfer(a[23:16], 8, d);
    xfer(a[15:8], 8, d);
    xfer(a[7:0], 8, d);
  endtask

  task automatic cmd1(input logic [7:0] op);
    logic [7:0] d;
    sel();
    xfer(op, 8, d);
    desel();
  endtask

  task automatic do_write(input logic [23:0] a, input logic [31:0] data, input int n);
    logic [7:0] d;
    sel();
    xfer(8'h02, 8, d);
    send_addr(a);
    for (int k = n - 1; k >= 0; k--) xfer(data[8*k +: 8], 8, d);
    desel();
  endtask

  task automatic do_read(input logic [23:0] a, input int n, output logic [31:0] got);
    logic [7:0] d;
    got = 32'h0;
    sel();
    xfer(8'h03, 8, d);
    send_addr(a);
    for (int k = 0; k < n; k++) begin
      xfer(8'h00, 8, d);
      got = {got[23:0], d};
    end
    desel();
  endtask

  task automatic rdsr(input int n, output logic [15:0] got);
    logic [7:0] d;
    got = 16'h0;
    sel();
    xfer(8'h05, 8, d);
    for (int k = 0; k < n; k++) begin
      xfer(8'h00, 8, d);
      got = {got[7:0], d};
    end
    desel();
  endtask

  initial begin
    logic [31:0] got;
    logic [15:0] st;
    logic [7:0]  d;

    vecs[0] = '{24'h000010, 8'hDE};
    vecs[1] = '{24'h000013, 8'hEF};
    vecs[2] = '{24'h0003FF, 8'h11};
    vecs[3] = '{24'h000000, 8'h22};
    vecs[4] = '{24'hFFFFFF, 8'h11};
    vecs[5] = '{24'hFFFC00, 8'h22};
    vecs[6] = '{24'h000410, 8'hDE};
    vecs[7] = '{24'h000020, 8'h77};
    vecs[8] = '{24'h000030, 8'h66};
    vecs[9] = '{24'h000012, 8'hBE};

    reset = 1'b1;
    bus.spi_ss = 1'b1;
    bus.spi_sck = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("reset_wel", {31'd0, wel}, 32'd0);
    check("reset_miso", {31'd0, bus.spi_miso}, 32'd0);
    check("reset_byte_written", {31'd0, byte_written}, 32'd0);
    check("reset_cmd_error", {31'd0, cmd_error}, 32'd0);

    do_write(24'h000030, 32'h55, 1);
    check("write_no_wel_err", ce_cnt, 32'd1);
    check("write_no_wel_bw", bw_cnt, 32'd0);

    cmd1(8'h06);
    check("wren_wel", {31'd0, wel}, 32'd1);
    rdsr(2, st);
    check("rdsr_two_bytes", {16'd0, st}, 32'h0202);

    do_write(24'h000010, 32'hDEADBEEF, 4);
    check("write4_bw", bw_cnt, 32'd4);
    do_write(24'h000030, 32'h66, 1);
    do_read(24'h000010, 4, got);
    check("read4_stream", got, 32'hDEADBEEF);

    do_write(24'h0003FF, 32'h1122, 2);
    check("write_wrap_bw", bw_cnt, 32'd7);
    do_read(24'hFFFFFF, 2, got);
    check("read_wrap_stream", got, 32'h1122);

    do_write(24'h000020, 32'h77, 1);
    sel();
    xfer(8'h02, 8, d);
    send_addr(24'h000020);
    xfer(8'h5A, 4, d);
    desel();
    check("partial_no_bw", bw_cnt, 32'd8);
    rdsr(1, st);
    check("after_partial_rdsr", {16'd0, st}, 32'h0002);
    check("wel_persists", {31'd0, wel}, 32'd1);

    sel();
    xfer(8'h9F, 8, d);
    for (int k = 0; k < 4; k++) begin
      xfer(8'hFF, 8, d);
      check("ignore_miso_zero", {24'd0, d}, 32'd0);
    end
    desel();
    check("bad_opcode_err", ce_cnt, 32'd2);
    cmd1(8'h04);
    check("wrdi_wel", {31'd0, wel}, 32'd0);
    do_write(24'h000030, 32'h55, 1);
    check("write_after_wrdi_err", ce_cnt, 32'd3);
    check("write_after_wrdi_bw", bw_cnt, 32'd8);

    for (int v = 0; v < 10; v++) begin
      do_read(vecs[v].addr, 1, got);
      check($sformatf("table_read_%0d", v), got, {24'd0, vecs[v].exp});
    end

    sel();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    xfer(8'h06, 8, d);
    desel();
    check("no_decode_until_reselect", {31'd0, wel}, 32'd0);
    cmd1(8'h06);
    check("decode_after_reselect", {31'd0, wel}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
